bp_branch_profile_unit: RTL and testbench
=========================================

BP_BRANCH_PROFILE_UNIT -- requirements
Module: bp_branch_profile_unit

Interface
REQ-001 Parameter vaddr_width_p, default 39, width of branch target address.
REQ-002 Parameter cnt_width_p, default 32, width of each scalar statistics counter.
REQ-003 Parameter hist_els_p, default 64, histogram table entries; power of two, at least 2.
REQ-004 Parameter hist_cnt_width_p, default 16, width of per-entry occurrence and miss counters.
REQ-005 clk_i  input  1  clock; all state updates on posedge.
REQ-006 reset_li  input  1  reset, asynchronous, active-low.
REQ-007 commit_v_i  input  1  one instruction committed this cycle.
REQ-008 attaboy_v_i  input  1  accepted FE attaboy command (correct prediction).
REQ-009 redirect_v_i  input  1  accepted FE PC-redirect command (misprediction).
REQ-010 vaddr_i  input  vaddr_width_p  command target address; qualified by attaboy_v_i or redirect_v_i.
REQ-011 is_br_i, is_jal_i, is_jalr_i, src_btb_i, src_ret_i  input  1 each  branch metadata fields.
REQ-012 clear_i  input  1  zero all statistics.
REQ-013 dump_i  input  1  start readout.
REQ-014 dump_v_o / dump_ready_i  output / input  1 / 1  readout valid/ready handshake.
REQ-015 dump_kind_o  output  1  0 = scalar record, 1 = table record.
REQ-016 dump_idx_o  output  max(4,log2(hist_els_p))  scalar id or table index.
REQ-017 dump_data_o  output  cnt_width_p  scalar value; for table records {valid, tag, occ, miss}, zero-extended or truncated to cnt_width_p from the MSB side.
REQ-018 dump_done_o  output  1  one-cycle pulse at readout end; busy_o  output  1  high while not idle.

Function
REQ-019 Scalar ids: 0 instr, 1 attaboy, 2 redirect, 3 br, 4 jal, 5 jalr, 6 btb_hit, 7 ras_hit, 8 dropped.
REQ-020 Each scalar counter SHALL saturate at all-ones and SHALL never wrap.
REQ-021 An event is attaboy_v_i or redirect_v_i; if both are high, redirect is taken and attaboy is ignored.
REQ-022 On an event: increment attaboy or redirect, and increment br, jal, jalr by the corresponding metadata bit.
REQ-023 btb_hit and ras_hit SHALL increment by src_btb_i and src_ret_i on attaboy only.
REQ-024 instr SHALL increment by commit_v_i every non-clear cycle, including during a dump.
REQ-025 Counter updates SHALL be visible on dump_data_o one cycle after the event; latency is 1.
REQ-026 Table index = vaddr_i[log2(hist_els_p)+1:2]; tag = the remaining upper bits.
REQ-027 Hit (valid and tag match): occ += 1 and miss += redirect; both counters saturate.
REQ-028 Miss or invalid entry: overwrite with valid=1, new tag, occ=1, miss=redirect.
REQ-029 FSM states: e_idle, e_scalar, e_table, e_done.
REQ-030 Transitions: idle->scalar on dump_i; scalar->table after id 8 handshakes; table->done after index hist_els_p-1 handshakes; done->idle unconditionally, with dump_done_o high for that one cycle.
REQ-031 dump_v_o SHALL be high in e_scalar and e_table only; a record SHALL advance only on dump_v_o & dump_ready_i; outputs SHALL hold stable while stalled.
REQ-032 Table records SHALL be emitted for every index, valid or not.
REQ-033 While busy_o is high, table updates SHALL be suppressed and dropped SHALL increment per event; scalar counters SHALL keep counting.
REQ-034 clear_i in e_idle SHALL zero all counters and invalidate all entries in one cycle; an event in the same cycle is discarded and not counted.
REQ-035 clear_i while busy_o is high SHALL be ignored; dump_i while busy_o is high SHALL be ignored.

Reset
REQ-036 Assertion of reset_li SHALL immediately zero all counters, invalidate the table, set state to e_idle, and drive dump_v_o, dump_done_o and busy_o to 0.
REQ-037 Reset mid-dump SHALL abort the readout with no dump_done_o pulse.

Structure
REQ-038 The state enum, scalar-id enum and table-entry struct SHALL reside in bp_common_pkg.
REQ-039 A sub-module bp_branch_sat_counter (width, increment-enable, increment amount, clear, saturation) SHALL be instantiated for every scalar counter.
REQ-040 Table storage SHALL be flops, not SRAM, so that read-modify-write completes in one cycle.

Verification
REQ-041 1000 commits, 10 attaboys at vaddr 0x80000100 with is_br=1, then dump -> instr=1000, attaboy=10, br=10, entry index 0 has occ=10, miss=0.
REQ-042 Same-cycle attaboy and redirect at 0x80000200 -> redirect=1, attaboy=0, entry miss=1.
REQ-043 With cnt_width_p=4, 20 commits -> instr reads 15.
REQ-044 hist_els_p=64; 0x80000100 then 0x80001100 (same index, different tag) -> entry holds the new tag with occ=1.
REQ-045 Dump with dump_ready_i toggled every other cycle, plus 3 events during the dump -> 9+64 records in order with stable data while stalled, dropped=3, a single dump_done_o pulse.
REQ-046 reset_li asserted low during e_table -> dump_v_o=0 and busy_o=0 immediately, and every counter reads 0 on the next dump.

Source files
------------

// File: rtl/bp_common_pkg.sv
// Shared types for the branch profiling unit: dump FSM states, scalar counter ids,
// and the history-table entry layout.
package bp_common_pkg;

  localparam int bp_num_scalars_gp  = 9;
  // Entry fields are sized for the widest supported configuration; narrower
  // configurations keep the unused upper bits at zero.
  localparam int bp_hist_tag_max_gp = 64;
  localparam int bp_hist_cnt_max_gp = 32;

  typedef enum logic [1:0] {
    e_idle   = 2'd0,
    e_scalar = 2'd1,
    e_table  = 2'd2,
    e_done   = 2'd3
  } bp_prof_state_e;

  typedef enum logic [3:0] {
    e_sc_instr    = 4'd0,
    e_sc_attaboy  = 4'd1,
    e_sc_redirect = 4'd2,
    e_sc_br       = 4'd3,
    e_sc_jal      = 4'd4,
    e_sc_jalr     = 4'd5,
    e_sc_btb_hit  = 4'd6,
    e_sc_ras_hit  = 4'd7,
    e_sc_dropped  = 4'd8
  } bp_prof_scalar_e;

  typedef struct packed {
    logic                          valid;
    logic [bp_hist_tag_max_gp-1:0] tag;
    logic [bp_hist_cnt_max_gp-1:0] occ;
    logic [bp_hist_cnt_max_gp-1:0] miss;
  } bp_hist_entry_s;

  function automatic logic [bp_hist_cnt_max_gp-1:0] bp_sat_inc(
    input logic [bp_hist_cnt_max_gp-1:0] val,
    input logic [bp_hist_cnt_max_gp-1:0] max_val,
    input logic                          inc
  );
    if (inc && (val < max_val)) begin
      return val + 32'd1;
    end else begin
      return val;
    end
  endfunction

endpackage

// File: rtl/bp_branch_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module bp_branch_sat_counter #(
  parameter int width_p     = 32,
  parameter int amt_width_p = 1
) (
  input  logic                   clk_i,
  input  logic                   reset_li,
  input  logic                   clear_i,
  input  logic                   inc_v_i,
  input  logic [amt_width_p-1:0] amt_i,
  output logic [width_p-1:0]     count_o,
  output logic                   sat_o
);

  localparam int sum_width_lp = width_p + 1;

  logic [width_p:0] sum;

  assign sum   = {1'b0, count_o} + sum_width_lp'(amt_i);
  assign sat_o = &count_o;

  // Carry out of the sum means the increment would wrap, so pin at all-ones.
  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li) begin
      count_o <= '0;
    end else if (clear_i) begin
      count_o <= '0;
    end else if (inc_v_i) begin
      count_o <= sum[width_p] ? {width_p{1'b1}} : sum[width_p-1:0];
    end
  end

endmodule

// File: rtl/bp_branch_profile_unit.sv
// Branch prediction profiler: scalar event counters plus a direct-mapped target
// history table, read out as a stream of records over a valid/ready port.
module bp_branch_profile_unit
  import bp_common_pkg::*;
#(
  parameter int vaddr_width_p    = 39,
  parameter int cnt_width_p      = 32,
  parameter int hist_els_p       = 64,
  parameter int hist_cnt_width_p = 16,
  localparam int lg_hist_els_lp  = $clog2(hist_els_p),
  localparam int idx_width_lp    = (lg_hist_els_lp > 4) ? lg_hist_els_lp : 4
) (
  input  logic                     clk_i,
  input  logic                     reset_li,
  input  logic                     commit_v_i,
  input  logic                     attaboy_v_i,
  input  logic                     redirect_v_i,
  input  logic [vaddr_width_p-1:0] vaddr_i,
  input  logic                     is_br_i,
  input  logic                     is_jal_i,
  input  logic                     is_jalr_i,
  input  logic                     src_btb_i,
  input  logic                     src_ret_i,
  input  logic                     clear_i,
  input  logic                     dump_i,
  output logic                     dump_v_o,
  input  logic                     dump_ready_i,
  output logic                     dump_kind_o,
  output logic [idx_width_lp-1:0]  dump_idx_o,
  output logic [cnt_width_p-1:0]   dump_data_o,
  output logic                     dump_done_o,
  output logic                     busy_o
);

  localparam int tag_width_lp = vaddr_width_p - lg_hist_els_lp - 2;
  localparam int rec_width_lp = 1 + tag_width_lp + 2 * hist_cnt_width_p;
  localparam logic [idx_width_lp-1:0] last_scalar_lp = idx_width_lp'(bp_num_scalars_gp - 1);
  localparam logic [idx_width_lp-1:0] last_entry_lp  = idx_width_lp'(hist_els_p - 1);
  localparam logic [bp_hist_cnt_max_gp-1:0] hist_max_lp =
    bp_hist_cnt_max_gp'((64'd1 << hist_cnt_width_p) - 64'd1);

  bp_prof_state_e            state_r, state_n;
  logic [idx_width_lp-1:0]   idx_r, idx_n, nxt_idx;
  logic [cnt_width_p-1:0]    data_r, data_n;
  logic                      busy, fire;
  logic                      redirect, attaboy, event_v, do_clear, table_upd;
  logic [bp_num_scalars_gp-1:0] cnt_en, cnt_amt, sat_unused;
  logic [cnt_width_p-1:0]    scalar [16];
  logic                      vaddr_unused;

  bp_hist_entry_s            hist_r [hist_els_p];
  bp_hist_entry_s            cur_e, nxt_e, rd_e;
  logic [lg_hist_els_lp-1:0] upd_idx, rd_idx;
  logic [tag_width_lp-1:0]   upd_tag;
  logic                      hit;
  logic [rec_width_lp-1:0]   rd_rec;
  logic [cnt_width_p-1:0]    tbl_data;

  assign busy         = (state_r != e_idle);
  assign redirect     = redirect_v_i;
  assign attaboy      = attaboy_v_i & ~redirect_v_i;
  assign event_v      = attaboy | redirect;
  assign do_clear     = clear_i & ~busy;
  assign table_upd    = event_v & ~busy & ~do_clear;
  assign upd_idx      = vaddr_i[lg_hist_els_lp+1:2];
  assign upd_tag      = vaddr_i[vaddr_width_p-1:lg_hist_els_lp+2];
  assign vaddr_unused = ^vaddr_i[1:0];

  // Per-counter enable and amount; metadata bits act as the increment amount.
  always_comb begin
    cnt_en                 = '0;
    cnt_amt                = '0;
    cnt_en[e_sc_instr]     = 1'b1;
    cnt_amt[e_sc_instr]    = commit_v_i;
    cnt_en[e_sc_attaboy]   = event_v;
    cnt_amt[e_sc_attaboy]  = attaboy;
    cnt_en[e_sc_redirect]  = event_v;
    cnt_amt[e_sc_redirect] = redirect;
    cnt_en[e_sc_br]        = event_v;
    cnt_amt[e_sc_br]       = is_br_i;
    cnt_en[e_sc_jal]       = event_v;
    cnt_amt[e_sc_jal]      = is_jal_i;
    cnt_en[e_sc_jalr]      = event_v;
    cnt_amt[e_sc_jalr]     = is_jalr_i;
    cnt_en[e_sc_btb_hit]   = attaboy;
    cnt_amt[e_sc_btb_hit]  = src_btb_i;
    cnt_en[e_sc_ras_hit]   = attaboy;
    cnt_amt[e_sc_ras_hit]  = src_ret_i;
    cnt_en[e_sc_dropped]   = busy;
    cnt_amt[e_sc_dropped]  = event_v;
  end

  for (genvar i = 0; i < 16; i++) begin : g_scalar
    if (i < bp_num_scalars_gp) begin : g_cnt
      bp_branch_sat_counter #(
        .width_p     (cnt_width_p),
        .amt_width_p (1)
      ) u_cnt (
        .clk_i    (clk_i),
        .reset_li (reset_li),
        .clear_i  (do_clear),
        .inc_v_i  (cnt_en[i]),
        .amt_i    (cnt_amt[i]),
        .count_o  (scalar[i]),
        .sat_o    (sat_unused[i])
      );
    end else begin : g_pad
      assign scalar[i] = '0;
    end
  end

  // Read-modify-write of the indexed history entry.
  always_comb begin
    cur_e = hist_r[upd_idx];
    hit   = cur_e.valid && (cur_e.tag == bp_hist_tag_max_gp'(upd_tag));
    nxt_e = cur_e;
    if (hit) begin
      nxt_e.occ  = bp_sat_inc(cur_e.occ, hist_max_lp, 1'b1);
      nxt_e.miss = bp_sat_inc(cur_e.miss, hist_max_lp, redirect);
    end else begin
      nxt_e.valid = 1'b1;
      nxt_e.tag   = bp_hist_tag_max_gp'(upd_tag);
      nxt_e.occ   = 32'd1;
      nxt_e.miss  = {31'd0, redirect};
    end
  end

  // History table storage; flops so the update lands in a single cycle.
  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li) begin
      for (int i = 0; i < hist_els_p; i++) hist_r[i] <= '0;
    end else if (do_clear) begin
      for (int i = 0; i < hist_els_p; i++) hist_r[i] <= '0;
    end else if (table_upd) begin
      hist_r[upd_idx] <= nxt_e;
    end
  end

  assign nxt_idx = idx_r + {{(idx_width_lp-1){1'b0}}, 1'b1};
  assign fire    = dump_v_o & dump_ready_i;

  // Table record for the next index to be shown (entry 0 when leaving the scalars).
  always_comb begin
    rd_idx   = (state_r == e_table) ? nxt_idx[lg_hist_els_lp-1:0] : '0;
    rd_e     = hist_r[rd_idx];
    rd_rec   = {rd_e.valid, rd_e.tag[tag_width_lp-1:0],
                rd_e.occ[hist_cnt_width_p-1:0], rd_e.miss[hist_cnt_width_p-1:0]};
    tbl_data = cnt_width_p'(rd_rec);
  end

  // Readout sequencing; a record is captured when it is loaded so it stays stable while stalled.
  always_comb begin
    state_n = state_r;
    idx_n   = idx_r;
    data_n  = data_r;
    case (state_r)
      e_idle: begin
        if (dump_i) begin
          state_n = e_scalar;
          idx_n   = '0;
          data_n  = scalar[0];
        end else begin
          state_n = e_idle;
        end
      end
      e_scalar: begin
        if (fire && (idx_r == last_scalar_lp)) begin
          state_n = e_table;
          idx_n   = '0;
          data_n  = tbl_data;
        end else if (fire) begin
          idx_n  = nxt_idx;
          data_n = scalar[nxt_idx[3:0]];
        end else begin
          idx_n = idx_r;
        end
      end
      e_table: begin
        if (fire && (idx_r == last_entry_lp)) begin
          state_n = e_done;
          idx_n   = '0;
          data_n  = '0;
        end else if (fire) begin
          idx_n  = nxt_idx;
          data_n = tbl_data;
        end else begin
          idx_n = idx_r;
        end
      end
      e_done:  state_n = e_idle;
      default: state_n = e_idle;
    endcase
  end

  // Readout state registers.
  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li) begin
      state_r <= e_idle;
      idx_r   <= '0;
      data_r  <= '0;
    end else begin
      state_r <= state_n;
      idx_r   <= idx_n;
      data_r  <= data_n;
    end
  end

  assign dump_v_o    = (state_r == e_scalar) || (state_r == e_table);
  assign dump_kind_o = (state_r == e_table);
  assign dump_idx_o  = idx_r;
  assign dump_data_o = data_r;
  assign dump_done_o = (state_r == e_done);
  assign busy_o      = busy;

endmodule

// File: tb/tb_bp_branch_profile_unit.sv
// Self-checking bench: directed scenarios checked from a vector table, plus randomized
// traffic compared against an arithmetic reference model of counters and table.
module tb_bp_branch_profile_unit;

  localparam int VW = 39, CW = 32, HE = 64, HCW = 16, LG = 6, TW = VW - LG - 2;
  localparam int NREC = 9 + HE, IW = 6;
  localparam longint CMAX = 64'hFFFF_FFFF, HMAX = 65535;

  logic clk, reset_li, commit_v, attaboy_v, redirect_v;
  logic is_br, is_jal, is_jalr, src_btb, src_ret, clear, dump, dump_ready;
  logic [VW-1:0] vaddr;
  logic dump_v, dump_kind, dump_done, busy;
  logic [IW-1:0] dump_idx;
  logic [CW-1:0] dump_data;
  logic dump_v4, dump_kind4, dump_done4, busy4;
  logic [IW-1:0] dump_idx4;
  logic [3:0] dump_data4;

  bp_branch_profile_unit #(.vaddr_width_p(VW), .cnt_width_p(CW), .hist_els_p(HE),
                           .hist_cnt_width_p(HCW)) dut (
    .clk_i(clk), .reset_li(reset_li), .commit_v_i(commit_v), .attaboy_v_i(attaboy_v),
    .redirect_v_i(redirect_v), .vaddr_i(vaddr), .is_br_i(is_br), .is_jal_i(is_jal),
    .is_jalr_i(is_jalr), .src_btb_i(src_btb), .src_ret_i(src_ret), .clear_i(clear),
    .dump_i(dump), .dump_v_o(dump_v), .dump_ready_i(dump_ready), .dump_kind_o(dump_kind),
    .dump_idx_o(dump_idx), .dump_data_o(dump_data), .dump_done_o(dump_done), .busy_o(busy));

  bp_branch_profile_unit #(.vaddr_width_p(VW), .cnt_width_p(4), .hist_els_p(HE),
                           .hist_cnt_width_p(HCW)) dut4 (
    .clk_i(clk), .reset_li(reset_li), .commit_v_i(commit_v), .attaboy_v_i(attaboy_v),
    .redirect_v_i(redirect_v), .vaddr_i(vaddr), .is_br_i(is_br), .is_jal_i(is_jal),
    .is_jalr_i(is_jalr), .src_btb_i(src_btb), .src_ret_i(src_ret), .clear_i(clear),
    .dump_i(dump), .dump_v_o(dump_v4), .dump_ready_i(dump_ready), .dump_kind_o(dump_kind4),
    .dump_idx_o(dump_idx4), .dump_data_o(dump_data4), .dump_done_o(dump_done4), .busy_o(busy4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0, bad = 0;

  // Reference model state
  longint sc [9];
  bit     mv [HE];
  longint mtag [HE], mocc [HE], mmiss [HE];
  int     mst;   // 0 idle, 1 emitting records, 2 done cycle
  int     mrec;
  logic [31:0] mexp;
  logic [3:0]  mexp4;
  int     cur_ph;
  logic [31:0] cap [5][NREC];
  logic [3:0]  cap4 [5];

  typedef struct { int ph; int rec; logic [31:0] exp; } vec_t;
  vec_t vecs [17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint satadd(input longint a, input longint b, input longint m);
    return (a + b > m) ? m : a + b;
  endfunction

  function automatic logic [31:0] rec_value(input int r);
    logic [127:0] full;
    logic [63:0]  t, o, m;
    int e;
    if (r < 9) return sc[r][31:0];
    e = r - 9;
    t = mtag[e]; o = mocc[e]; m = mmiss[e];
    full = {64'd0, mv[e], t[TW-1:0], o[HCW-1:0], m[HCW-1:0]};
    return full[CW-1:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 9; i++) sc[i] = 0;
    for (int i = 0; i < HE; i++) begin mv[i] = 0; mtag[i] = 0; mocc[i] = 0; mmiss[i] = 0; end
    mst = 0; mrec = 0;
  endtask

  task automatic model_update(input bit mbusy);
    bit att, red, ev;
    int idx;
    longint tag;
    red = redirect_v; att = attaboy_v && !redirect_v; ev = att || red;
    if (clear && !mbusy) begin
      for (int i = 0; i < 9; i++) sc[i] = 0;
      for (int i = 0; i < HE; i++) begin mv[i] = 0; mtag[i] = 0; mocc[i] = 0; mmiss[i] = 0; end
    end else begin
      sc[0] = satadd(sc[0], longint'(commit_v), CMAX);
      if (ev) begin
        sc[1] = satadd(sc[1], longint'(att), CMAX);
        sc[2] = satadd(sc[2], longint'(red), CMAX);
        sc[3] = satadd(sc[3], longint'(is_br), CMAX);
        sc[4] = satadd(sc[4], longint'(is_jal), CMAX);
        sc[5] = satadd(sc[5], longint'(is_jalr), CMAX);
        if (att) begin
          sc[6] = satadd(sc[6], longint'(src_btb), CMAX);
          sc[7] = satadd(sc[7], longint'(src_ret), CMAX);
        end
        if (mbusy) sc[8] = satadd(sc[8], 1, CMAX);
        else begin
          idx = int'((longint'(vaddr) >> 2) % HE);
          tag = longint'(vaddr) >> (LG + 2);
          if (mv[idx] && mtag[idx] == tag) begin
            mocc[idx]  = satadd(mocc[idx], 1, HMAX);
            mmiss[idx] = satadd(mmiss[idx], longint'(red), HMAX);
          end else begin
            mv[idx] = 1; mtag[idx] = tag; mocc[idx] = 1; mmiss[idx] = longint'(red);
          end
        end
      end
    end
  endtask

  // One clock: check outputs against the model, advance the model, cross the edge.
  task automatic tick();
    bit mbusy;
    int eidx;
    mbusy = (mst != 0);
    chk("busy", 64'(busy), 64'(mbusy));
    chk("busy_4bit", 64'(busy4), 64'(mbusy));
    chk("dump_v", 64'(dump_v), 64'(mst == 1));
    chk("dump_v_4bit", 64'(dump_v4), 64'(mst == 1));
    chk("dump_done", 64'(dump_done), 64'(mst == 2));
    chk("dump_done_4bit", 64'(dump_done4), 64'(mst == 2));
    if (mst == 1) begin
      eidx = (mrec < 9) ? mrec : mrec - 9;
      chk("dump_kind", 64'(dump_kind), 64'(mrec >= 9));
      chk("dump_idx", 64'(dump_idx), 64'(eidx));
      chk("dump_idx_4bit", 64'(dump_idx4), 64'(eidx));
      chk("dump_kind_4bit", 64'(dump_kind4), 64'(mrec >= 9));
      chk("dump_data", 64'(dump_data), 64'(mexp));
      if (mrec == 0) chk("instr_4bit", 64'(dump_data4), 64'(mexp4));
      if (dump_ready && cur_ph >= 0) begin
        cap[cur_ph][mrec] = dump_data;
        if (mrec == 0) cap4[cur_ph] = dump_data4;
      end
    end
    case (mst)
      0: if (dump) begin
           mst = 1; mrec = 0; mexp = rec_value(0);
           mexp4 = (sc[0] > 15) ? 4'd15 : 4'(sc[0]);
         end
      1: if (dump_ready) begin
           mrec++;
           if (mrec == NREC) mst = 2;
           else mexp = rec_value(mrec);
         end
      default: mst = 0;
    endcase
    model_update(mbusy);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    commit_v = 0; attaboy_v = 0; redirect_v = 0; is_br = 0; is_jal = 0; is_jalr = 0;
    src_btb = 0; src_ret = 0; clear = 0; dump = 0; dump_ready = 1; vaddr = '0;
  endtask

  task automatic run_dump();
    dump = 1; tick(); dump = 0;
    for (int i = 0; i < 2000 && mst != 0; i++) tick();
  endtask

  task automatic do_clear();
    clear = 1; tick(); clear = 0;
  endtask

  initial begin
    vecs[0]  = '{0, 0, 32'd1000};      vecs[1]  = '{0, 1, 32'd10};
    vecs[2]  = '{0, 2, 32'd0};         vecs[3]  = '{0, 3, 32'd10};
    vecs[4]  = '{0, 8, 32'd0};         vecs[5]  = '{0, 9, 32'h000A_0000};
    vecs[6]  = '{0, 10, 32'd0};        vecs[7]  = '{1, 1, 32'd0};
    vecs[8]  = '{1, 2, 32'd1};         vecs[9]  = '{1, 3, 32'd0};
    vecs[10] = '{1, 9, 32'h0001_0001}; vecs[11] = '{2, 1, 32'd2};
    vecs[12] = '{2, 9, 32'h0001_0000}; vecs[13] = '{3, 8, 32'd3};
    vecs[14] = '{3, 9, 32'd0};         vecs[15] = '{4, 0, 32'd0};
    vecs[16] = '{4, 8, 32'd0};

    cur_ph = -1;
    idle_inputs();
    model_reset();
    reset_li = 0;
    #2;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_dump_v", 64'(dump_v), 64'd0);
    chk("reset_dump_done", 64'(dump_done), 64'd0);
    #1 reset_li = 1;
    @(posedge clk); #1;

    // 1000 commits then 10 correct branches at one target
    commit_v = 1;
    repeat (1000) tick();
    commit_v = 0; attaboy_v = 1; is_br = 1; vaddr = 39'h00_8000_0100;
    repeat (10) tick();
    idle_inputs();
    cur_ph = 0; run_dump();

    // attaboy and redirect in the same cycle
    cur_ph = -1; do_clear();
    attaboy_v = 1; redirect_v = 1; vaddr = 39'h00_8000_0200; tick();
    idle_inputs();
    cur_ph = 1; run_dump();

    // same index, different tag replaces the entry
    cur_ph = -1; do_clear();
    attaboy_v = 1; vaddr = 39'h00_8000_0100; tick();
    vaddr = 39'h00_8000_1100; tick();
    idle_inputs();
    cur_ph = 2; run_dump();

    // stalled readout with events, a clear and a dump request while busy
    cur_ph = -1; do_clear();
    cur_ph = 3;
    dump = 1; tick(); dump = 0;
    for (int i = 0; i < 400 && mst != 0; i++) begin
      dump_ready = i[0];
      attaboy_v  = (i < 3);
      vaddr      = 39'h00_8000_0300;
      clear      = (i == 5);
      dump       = (i == 7);
      commit_v   = (i > 20);
      tick();
    end
    idle_inputs();

    // randomized traffic against the model
    cur_ph = -1;
    for (int i = 0; i < 5000; i++) begin
      commit_v   = ($urandom_range(0, 3) != 0);
      attaboy_v  = ($urandom_range(0, 3) == 0);
      redirect_v = ($urandom_range(0, 7) == 0);
      is_br = $urandom_range(0, 1); is_jal = $urandom_range(0, 1); is_jalr = $urandom_range(0, 1);
      src_btb = $urandom_range(0, 1); src_ret = $urandom_range(0, 1);
      vaddr = 39'h00_8000_0000 + (39'($urandom_range(0, 3)) << 12)
            + (39'($urandom_range(0, 7)) << 2) + 39'($urandom_range(0, 3));
      clear      = ($urandom_range(0, 149) == 0);
      dump       = ($urandom_range(0, 399) == 0);
      dump_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 300 && mst != 0; i++) tick();

    // reset in the middle of the table readout
    commit_v = 1; attaboy_v = 1; tick(); idle_inputs();
    dump = 1; tick(); dump = 0;
    for (int i = 0; i < 200 && !(mst == 1 && mrec >= 20); i++) tick();
    reset_li = 0;
    #1;
    chk("midreset_dump_v", 64'(dump_v), 64'd0);
    chk("midreset_busy", 64'(busy), 64'd0);
    chk("midreset_dump_done", 64'(dump_done), 64'd0);
    model_reset();
    #2 reset_li = 1;
    cur_ph = 4; run_dump();
    cur_ph = -1;

    for (int i = 0; i < 17; i++)
      chk($sformatf("vec%0d_ph%0d_rec%0d", i, vecs[i].ph, vecs[i].rec),
          64'(cap[vecs[i].ph][vecs[i].rec]), 64'(vecs[i].exp));
    chk("instr_sat_4bit", 64'(cap4[0]), 64'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
